// File: rtl/alu_cmd_driver_if.sv
// Bundles the command, ALU and response channels between the ALU command driver and its environment.
// The master view belongs to the driver. The slave view belongs to the command source, the ALU and the response sink.
interface alu_cmd_driver_if #(
    parameter int data_width = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [data_width-1:0] cmd_a;
    logic [data_width-1:0] cmd_b;
    logic [3:0]            cmd_func;

    logic [data_width-1:0] alu_A;
    logic [data_width-1:0] alu_B;
    logic [3:0]            alu_FuncCode;
    logic [data_width-1:0] alu_C;
    logic                  alu_OverflowFlag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [data_width-1:0] rsp_c;
    logic                  rsp_overflow;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_func,
        output cmd_ready,
        output alu_A, alu_B, alu_FuncCode,
        input  alu_C, alu_OverflowFlag,
        output rsp_valid, rsp_c, rsp_overflow,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_func,
        input  cmd_ready,
        input  alu_A, alu_B, alu_FuncCode,
        output alu_C, alu_OverflowFlag,
        input  rsp_valid, rsp_c, rsp_overflow,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Drives registered operands onto a combinational ALU, waits a fixed settle time, captures the result,
// and returns it over a valid/ready channel. It also keeps a sticky overflow flag and a count of completed operations.
module alu_cmd_driver #(
    parameter int         data_width    = 16,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         CNT_WIDTH     = 16,
    parameter logic [3:0] FUNC_ADD      = 4'h2,
    parameter logic [3:0] FUNC_SUB      = 4'h6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_cmd_driver_if.master     bus,
    input  logic                 clear_sticky,
    output logic                 sticky_overflow,
    output logic [CNT_WIDTH-1:0] op_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
        $error("alu_cmd_driver: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } driverState;

    driverState            state;
    logic [3:0]            settleCnt;
    logic [data_width-1:0] captureC;
    logic                  overflowMasked;
    logic                  captureNow;

    assign captureC = bus.alu_C;

    // The ALU leaves its flag stale for anything except add and subtract, so the flag is ignored for other codes.
    assign overflowMasked = bus.alu_OverflowFlag &
                            ((bus.alu_FuncCode == FUNC_ADD) || (bus.alu_FuncCode == FUNC_SUB));
    assign captureNow     = (state == SETTLE) && (settleCnt == 4'd1);

    // cmd_ready stays low while reset is asserted, even though the state is already IDLE.
    assign bus.cmd_ready  = (state == IDLE) & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            settleCnt        <= 4'd0;
            bus.alu_A        <= '0;
            bus.alu_B        <= '0;
            bus.alu_FuncCode <= 4'd0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_c        <= '0;
            bus.rsp_overflow <= 1'b0;
            sticky_overflow  <= 1'b0;
            op_count         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.alu_A        <= bus.cmd_a;
                        bus.alu_B        <= bus.cmd_b;
                        bus.alu_FuncCode <= bus.cmd_func;
                        settleCnt        <= 4'(SETTLE_CYCLES);
                        state            <= SETTLE;
                    end
                end
                SETTLE: begin
                    settleCnt <= settleCnt - 4'd1;
                    if (captureNow) begin
                        bus.rsp_c        <= captureC;
                        bus.rsp_overflow <= overflowMasked;
                        bus.rsp_valid    <= 1'b1;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // If an overflow capture and a clear happen on the same edge, the set takes priority.
            if (captureNow && overflowMasked) begin
                sticky_overflow <= 1'b1;
            end else if (clear_sticky) begin
                sticky_overflow <= 1'b0;
            end
        end
    end

endmodule
